param_decoder_seq: RTL and testbench
====================================

PARAM_DECODER_SEQ -- requirements
Module: param_decoder_seq

Interface
REQ-001 The block SHALL have parameter N, default 3, giving the select width; output width is 2^N.
REQ-002 The block SHALL have parameter SCAN_DIV, default 4, giving clock cycles per scan step; legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 en  input  1  global enable; 0 freezes all state except clr/rst effects.
REQ-006 load  input  1  one-cycle command; captures sel and mode.
REQ-007 clr  input  1  one-cycle command; returns block to IDLE.
REQ-008 mode  input  1  0 = HOLD (static decode), 1 = SCAN (walking one); sampled only with load.
REQ-009 sel  input  N  decode index (HOLD) or scan start index (SCAN); sampled only with load.
REQ-010 z  output  2^N  registered one-hot output, bit idx high when active, else all zero.
REQ-011 idx  output  N  registered current index.
REQ-012 active  output  1  registered; high in HOLD or SCAN.
REQ-013 wrap  output  1  registered one-cycle pulse on scan wrap-around.

Function
REQ-014 The block SHALL implement states IDLE, HOLD, SCAN held in a registered state machine.
REQ-015 IDLE: z = 0, active = 0, idx holds last value; wrap = 0.
REQ-016 load=1, en=1, clr=0 in any state: cycle k edge captures sel into idx, enters HOLD (mode=0) or SCAN (mode=1); z = one-hot(sel), active = 1 from cycle k+1 (latency 1).
REQ-017 HOLD: z and idx constant until next load, clr or rst.
REQ-018 SCAN: divider counter SHALL count 0..SCAN_DIV-1; on terminal count idx increments by 1 and z shifts accordingly; first step occurs SCAN_DIV cycles after entry.
REQ-019 SCAN wrap: idx = 2^N-1 stepping SHALL go to 0 and assert wrap for exactly the cycle idx=0 is first presented; scan continues indefinitely.
REQ-020 load during SCAN SHALL restart: divider cleared, idx = sel, new mode applied, no wrap pulse generated by the reload.
REQ-021 clr=1 (with en any value) SHALL force IDLE next edge: z = 0, active = 0, wrap = 0, divider cleared; clr takes priority over simultaneous load.
REQ-022 en=0: load ignored; divider, idx, state, z frozen; wrap forced 0; resuming en=1 continues divider from its frozen count.
REQ-023 z SHALL always be either all zero or exactly one bit set; z bit i high iff active=1 and idx=i.
REQ-024 Divider SHALL be sized ceil(log2(SCAN_DIV+1)) bits minimum; SCAN_DIV=1 steps every cycle.
REQ-025 All outputs SHALL be driven from registers; no combinational path from inputs to outputs.

Reset
REQ-026 rst=1 SHALL asynchronously force IDLE, z = 0, idx = 0, active = 0, wrap = 0, divider = 0.
REQ-027 rst asserted mid-SCAN SHALL take effect immediately without waiting for clk; after release the block stays IDLE until load.
REQ-028 First load accepted on the first rising edge after rst deasserts.

Verification (N=3, SCAN_DIV=2 unless stated)
REQ-029 Reset then load, mode=0, sel=5 -> next cycle z=8'b0010_0000, idx=5, active=1; held 20 cycles unchanged.
REQ-030 load, mode=1, sel=6 -> z=0x40 for 2 cycles, 0x80 for 2 cycles, then 0x01 with wrap=1 for one cycle only, then 0x02.
REQ-031 SCAN at idx=2, en=0 for 5 cycles then en=1 -> z stays 0x04 during pause; step timing resumes from frozen divider count.
REQ-032 load and clr asserted same cycle during HOLD sel=3 -> next cycle z=0, active=0; load discarded.
REQ-033 rst pulse between clock edges mid-SCAN -> z=0, idx=0, active=0 immediately; no output change until subsequent load.
REQ-034 SCAN_DIV=1, N=2, load mode=1 sel=0 -> z cycles 0x1,0x2,0x4,0x8,0x1 each cycle; wrap high every 4th cycle; one-hot check holds every cycle.

Source files
------------

// File: rtl/param_decoder_seq.sv
// param_decoder_seq: registered one-hot decoder with HOLD (static) and
// SCAN (walking-one) modes. The scan advances once every SCAN_DIV cycles.
module param_decoder_seq #(
  parameter int N        = 3,
  parameter int SCAN_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load,
  input  logic              clr,
  input  logic              mode,
  input  logic [N-1:0]      sel,
  output logic [(1<<N)-1:0] z,
  output logic [N-1:0]      idx,
  output logic              active,
  output logic              wrap
);

  localparam int W     = 1 << N;
  localparam int DIV_W = (SCAN_DIV < 2) ? 1 : $clog2(SCAN_DIV + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [N-1:0]     IDX_ONE  = N'(1);
  localparam logic [N-1:0]     IDX_LAST = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    SCAN = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     idx_q,   idx_d;
  logic [DIV_W-1:0] div_q,   div_d;
  logic [W-1:0]     z_q,     z_d;
  logic             active_q, active_d;
  logic             wrap_q,   wrap_d;

  // Next-state logic: clr beats everything, en=0 freezes, load beats stepping.
  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    state_d = state_q;
    idx_d   = idx_q;
    div_d   = div_q;
    wrap_d  = 1'b0;

    if (clr) begin
      state_d = IDLE;
      div_d   = '0;
    end else if (en) begin
      if (load) begin
        // Reload never produces a wrap pulse, even when landing on index 0.
        state_d = mode ? SCAN : HOLD;
        idx_d   = sel;
        div_d   = '0;
      end else if (state_q == SCAN) begin
        if (div_q == DIV_LAST) begin
          div_d  = '0;
          idx_d  = idx_q + IDX_ONE;
          wrap_d = (idx_q == IDX_LAST);
        end else begin
          div_d = div_q + DIV_ONE;
        end
      end
    end

    // Outputs are a pure function of the next registered state, so z stays one-hot.
    active_d = (state_d != IDLE);
    z_d      = '0;
    if (active_d) z_d[idx_d] = 1'b1;
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      div_q    <= '0;
      z_q      <= '0;
      active_q <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      div_q    <= div_d;
      z_q      <= z_d;
      active_q <= active_d;
      wrap_q   <= wrap_d;
    end
  end

  assign z      = z_q;
  assign idx    = idx_q;
  assign active = active_q;
  assign wrap   = wrap_q;

endmodule

// File: tb/tb_param_decoder_seq.sv
// Directed testbench for param_decoder_seq: HOLD, SCAN with wrap, pause,
// reload, clr priority, asynchronous reset, and a fast N=2/SCAN_DIV=1 scan.
module tb_param_decoder_seq;

  logic       clk;
  logic       rst;

  // Main instance: N=3, SCAN_DIV=2
  logic       en, load, clr, mode;
  logic [2:0] sel;
  logic [7:0] z;
  logic [2:0] idx;
  logic       active, wrap;

  // Fast instance: N=2, SCAN_DIV=1
  logic       en1, load1, clr1, mode1;
  logic [1:0] sel1;
  logic [3:0] z1;
  logic [1:0] idx1;
  logic       active1, wrap1;

  int checks = 0;
  int errors = 0;

  param_decoder_seq #(.N(3), .SCAN_DIV(2)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .clr(clr), .mode(mode),
    .sel(sel), .z(z), .idx(idx), .active(active), .wrap(wrap)
  );

  param_decoder_seq #(.N(2), .SCAN_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .en(en1), .load(load1), .clr(clr1), .mode(mode1),
    .sel(sel1), .z(z1), .idx(idx1), .active(active1), .wrap(wrap1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] ez, input logic [2:0] ei,
                         input logic ea, input logic ew);
    check({tag, ".z"},      32'(z),      32'(ez));
    check({tag, ".idx"},    32'(idx),    32'(ei));
    check({tag, ".active"}, 32'(active), 32'(ea));
    check({tag, ".wrap"},   32'(wrap),   32'(ew));
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected z sequence after a SCAN load with sel=6 (SCAN_DIV=2).
  logic [7:0] scan_z [7] = '{8'h40, 8'h40, 8'h80, 8'h80, 8'h01, 8'h01, 8'h02};
  logic [2:0] scan_i [7] = '{3'd6, 3'd6, 3'd7, 3'd7, 3'd0, 3'd0, 3'd1};
  logic       scan_w [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    rst  = 1'b1;
    en   = 1'b1; load  = 1'b0; clr  = 1'b0; mode  = 1'b0; sel  = '0;
    en1  = 1'b1; load1 = 1'b0; clr1 = 1'b0; mode1 = 1'b0; sel1 = '0;

    #12;
    chk_out("reset", 8'h00, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // HOLD sel=5, held for 20 cycles; first load right after reset release
    load = 1'b1; mode = 1'b0; sel = 3'd5;
    tick();
    load = 1'b0; sel = 3'd0;
    chk_out("hold_entry", 8'h20, 3'd5, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("hold_steady.z", 32'(z), 32'h20);
    end

    // SCAN from sel=6 through wrap
    load = 1'b1; mode = 1'b1; sel = 3'd6;
    tick();
    load = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) tick();
      chk_out($sformatf("scan6_%0d", i), scan_z[i], scan_i[i], 1'b1, scan_w[i]);
    end

    // Advance to idx=2 with divider at 1
    tick(); check("scan_pre.z0", 32'(z), 32'h02);
    tick(); check("scan_pre.z1", 32'(z), 32'h04);
    tick(); check("scan_pre.z2", 32'(z), 32'h04);

    // Pause 5 cycles; a load during the pause must be ignored
    en = 1'b0; load = 1'b1; mode = 1'b0; sel = 3'd7;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_out($sformatf("pause_%0d", i), 8'h04, 3'd2, 1'b1, 1'b0);
    end
    en = 1'b1; load = 1'b0;
    // Divider was frozen at its last count, so the step comes on the first edge
    tick();
    chk_out("resume", 8'h08, 3'd3, 1'b1, 1'b0);

    // Reload during SCAN to sel=0: divider cleared, no wrap pulse
    load = 1'b1; mode = 1'b1; sel = 3'd0;
    tick();
    load = 1'b0;
    chk_out("reload", 8'h01, 3'd0, 1'b1, 1'b0);
    tick(); check("reload_div.z", 32'(z), 32'h01);
    tick(); check("reload_step.z", 32'(z), 32'h02);

    // HOLD sel=3 then load+clr together: clr wins
    load = 1'b1; mode = 1'b0; sel = 3'd3;
    tick();
    chk_out("hold3", 8'h08, 3'd3, 1'b1, 1'b0);
    load = 1'b1; clr = 1'b1; mode = 1'b1; sel = 3'd5;
    tick();
    load = 1'b0; clr = 1'b0;
    chk_out("clr_prio", 8'h00, 3'd3, 1'b0, 1'b0);
    tick(); tick();
    chk_out("idle_stay", 8'h00, 3'd3, 1'b0, 1'b0);

    // clr works even with en=0
    load = 1'b1; mode = 1'b1; sel = 3'd4;
    tick();
    load = 1'b0;
    check("scan4.z", 32'(z), 32'h10);
    en = 1'b0; clr = 1'b1;
    tick();
    en = 1'b1; clr = 1'b0;
    chk_out("clr_en0", 8'h00, 3'd4, 1'b0, 1'b0);

    // Asynchronous reset mid-SCAN, between clock edges
    load = 1'b1; mode = 1'b1; sel = 3'd1;
    tick();
    load = 1'b0;
    tick(); tick();
    check("prerst.z", 32'(z), 32'h04);
    #2 rst = 1'b1;
    #1;
    chk_out("async_rst", 8'h00, 3'd0, 1'b0, 1'b0);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk_out("post_rst_idle", 8'h00, 3'd0, 1'b0, 1'b0);
    load = 1'b1; mode = 1'b0; sel = 3'd2;
    tick();
    load = 1'b0;
    chk_out("post_rst_load", 8'h04, 3'd2, 1'b1, 1'b0);

    // Fast instance: walking one every cycle, wrap every 4th cycle
    load1 = 1'b1; mode1 = 1'b1; sel1 = 2'd0;
    tick();
    load1 = 1'b0;
    check("fast_load.z", 32'(z1), 32'h1);
    check("fast_load.wrap", 32'(wrap1), 32'h0);
    for (int i = 1; i <= 8; i++) begin
      logic [1:0] ei;
      logic [3:0] ez;
      ei = 2'(i % 4);
      ez = 4'b0001 << ei;
      tick();
      check($sformatf("fast_%0d.z", i), 32'(z1), 32'(ez));
      check($sformatf("fast_%0d.idx", i), 32'(idx1), 32'(ei));
      check($sformatf("fast_%0d.wrap", i), 32'(wrap1), 32'(ei == 2'd0));
      check($sformatf("fast_%0d.onehot", i), 32'($onehot(z1)), 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
